// File: rtl/exmem_skid_pipe_pkg.sv
// Shared definitions for the EX/MEM skid pipeline: writeback source
// encodings, the default-width payload record and a payload width helper.
package exmem_skid_pipe_pkg;

  typedef enum logic [1:0] {
    MEM_TO_REG_ALU = 2'b00,
    MEM_TO_REG_MEM = 2'b01,
    MEM_TO_REG_PC4 = 2'b10
  } mem_to_reg_e;

  localparam int unsigned DEF_XLEN    = 32;
  localparam int unsigned DEF_INSTR_W = 32;
  localparam int unsigned DEF_RD_W    = 5;

  // EX/MEM payload at the default widths
  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_XLEN-1:0]    alu;
    logic [DEF_XLEN-1:0]    rs2;
    logic [DEF_XLEN-1:0]    pc;
    logic [1:0]             mem_to_reg;
    logic                   reg_write;
    logic [DEF_RD_W-1:0]    rd;
  } exmem_payload_t;

  function automatic int unsigned payload_width(input int unsigned xlen,
                                                input int unsigned instr_w,
                                                input int unsigned rd_w);
    return instr_w + 3 * xlen + 2 + 1 + rd_w;
  endfunction

endpackage

// File: rtl/exmem_skid_pipe_if.sv
// EX->MEM handshake and payload bundle. The slave modport is the pipe
// stage's view; the master modport is the surrounding EX/MEM logic.
interface exmem_skid_pipe_if #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned RD_W    = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [XLEN-1:0]    in_alu;
  logic [XLEN-1:0]    in_rs2;
  logic [XLEN-1:0]    in_pc;
  logic [1:0]         in_mem_to_reg;
  logic               in_reg_write;
  logic [RD_W-1:0]    in_rd;

  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [XLEN-1:0]    out_alu;
  logic [XLEN-1:0]    out_rs2;
  logic [XLEN-1:0]    out_pc;
  logic [1:0]         out_mem_to_reg;
  logic               out_reg_write;
  logic [RD_W-1:0]    out_rd;

  modport slave (
    input  in_valid, in_instr, in_alu, in_rs2, in_pc, in_mem_to_reg,
           in_reg_write, in_rd, out_ready,
    output in_ready, out_valid, out_instr, out_alu, out_rs2, out_pc,
           out_mem_to_reg, out_reg_write, out_rd
  );

  modport master (
    output in_valid, in_instr, in_alu, in_rs2, in_pc, in_mem_to_reg,
           in_reg_write, in_rd, out_ready,
    input  in_ready, out_valid, out_instr, out_alu, out_rs2, out_pc,
           out_mem_to_reg, out_reg_write, out_rd
  );
endinterface

// File: rtl/exmem_skid_pipe_slot.sv
// exmem_slot: one valid bit plus payload register. clear zeroes both,
// load captures d, unload drops valid while leaving the payload stale.
module exmem_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // reset/clear dominate, then load, then unload
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/exmem_skid_pipe.sv
// EX/MEM pipeline register with a one-entry skid buffer. in_ready comes
// straight from the skid valid flop, so out_ready never reaches it
// combinationally. Optional stall counter under macro EXMEM_STALL_CNT_EN.
module exmem_skid_pipe
  import exmem_skid_pipe_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned RD_W    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  exmem_skid_pipe_if.slave    bus
`ifdef EXMEM_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  localparam int unsigned PW = payload_width(XLEN, INSTR_W, RD_W);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    alu;
    logic [XLEN-1:0]    rs2;
    logic [XLEN-1:0]    pc;
    logic [1:0]         mem_to_reg;
    logic               reg_write;
    logic [RD_W-1:0]    rd;
  } payload_t;

  payload_t in_pl;
  payload_t main_d;
  payload_t main_q;
  payload_t skid_q;
  logic     main_v;
  logic     skid_v;
  logic     main_load;
  logic     main_unload;
  logic     skid_load;
  logic     skid_unload;
  logic     accept;
  logic     drain;

  assign in_pl = '{
    instr:      bus.in_instr,
    alu:        bus.in_alu,
    rs2:        bus.in_rs2,
    pc:         bus.in_pc,
    mem_to_reg: bus.in_mem_to_reg,
    reg_write:  bus.in_reg_write,
    rd:         bus.in_rd
  };

  assign accept = bus.in_valid && !skid_v;
  assign drain  = main_v && bus.out_ready;

  // steer accepted entries and skid refills between the two slots
  always_comb begin
    main_load   = 1'b0;
    main_unload = 1'b0;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    main_d      = in_pl;
    if (skid_v) begin
      // in_ready is low here, so no accept competes with the refill
      if (drain) begin
        main_load   = 1'b1;
        main_d      = skid_q;
        skid_unload = 1'b1;
      end
    end else if (accept) begin
      if (!main_v || drain) main_load = 1'b1;
      else                  skid_load = 1'b1;
    end else if (drain) begin
      main_unload = 1'b1;
    end
  end

  exmem_slot #(.W(PW)) u_main (
    .clk    (clk),
    .rst    (rst),
    .clear  (flush),
    .load   (main_load),
    .unload (main_unload),
    .d      (main_d),
    .valid  (main_v),
    .q      (main_q)
  );

  exmem_slot #(.W(PW)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .clear  (flush),
    .load   (skid_load),
    .unload (skid_unload),
    .d      (in_pl),
    .valid  (skid_v),
    .q      (skid_q)
  );

  assign bus.in_ready       = !skid_v;
  assign bus.out_valid      = main_v;
  assign bus.out_instr      = main_q.instr;
  assign bus.out_alu        = main_q.alu;
  assign bus.out_rs2        = main_q.rs2;
  assign bus.out_pc         = main_q.pc;
  assign bus.out_mem_to_reg = main_q.mem_to_reg;
  assign bus.out_reg_write  = main_q.reg_write && main_v;
  assign bus.out_rd         = main_q.rd;

`ifdef EXMEM_STALL_CNT_EN
  // count cycles where MEM holds a valid entry it cannot take; flush does not clear
  always_ff @(posedge clk) begin
    if (rst)                          stall_cnt <= '0;
    else if (main_v && !bus.out_ready) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_exmem_skid_pipe.sv
// Self-checking bench for exmem_skid_pipe: directed scenarios followed by
// randomized traffic, checked against a two-deep FIFO reference model.
module tb_exmem_skid_pipe;
  import exmem_skid_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
`ifdef EXMEM_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  exmem_skid_pipe_if #(.XLEN(32), .INSTR_W(32), .RD_W(5)) bus ();

  exmem_skid_pipe #(.XLEN(32), .INSTR_W(32), .RD_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
`ifdef EXMEM_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // reference model: ordered list of held entries, at most two
  exmem_payload_t mq[$];
  bit             m_zeroed = 1'b1;
  int unsigned    m_stall  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exmem_payload_t rand_payload();
    exmem_payload_t p;
    mem_to_reg_e    sel;
    case ($urandom_range(0, 2))
      0:       sel = MEM_TO_REG_ALU;
      1:       sel = MEM_TO_REG_MEM;
      default: sel = MEM_TO_REG_PC4;
    endcase
    p.instr      = $urandom;
    p.alu        = $urandom;
    p.rs2        = $urandom;
    p.pc         = $urandom;
    p.mem_to_reg = sel;
    p.reg_write  = 1'($urandom_range(0, 1));
    p.rd         = 5'($urandom_range(0, 31));
    return p;
  endfunction

  task automatic set_in(input logic v, input exmem_payload_t p);
    bus.in_valid      = v;
    bus.in_instr      = p.instr;
    bus.in_alu        = p.alu;
    bus.in_rs2        = p.rs2;
    bus.in_pc         = p.pc;
    bus.in_mem_to_reg = p.mem_to_reg;
    bus.in_reg_write  = p.reg_write;
    bus.in_rd         = p.rd;
  endtask

  function automatic exmem_payload_t cur_in();
    exmem_payload_t p;
    p.instr      = bus.in_instr;
    p.alu        = bus.in_alu;
    p.rs2        = bus.in_rs2;
    p.pc         = bus.in_pc;
    p.mem_to_reg = bus.in_mem_to_reg;
    p.reg_write  = bus.in_reg_write;
    p.rd         = bus.in_rd;
    return p;
  endfunction

  task automatic model_update();
    bit             rdy;
    bit             ov;
    bit             popped;
    exmem_payload_t tmp;
    rdy    = mq.size() < 2;
    ov     = mq.size() > 0;
    popped = 1'b0;
    if (rst) begin
      mq.delete();
      m_zeroed = 1'b1;
      m_stall  = 0;
    end else begin
      if (ov && !bus.out_ready) m_stall++;
      if (flush) begin
        mq.delete();
        m_zeroed = 1'b1;
      end else begin
        if (ov && bus.out_ready) begin
          tmp    = mq.pop_front();
          popped = 1'b1;
        end
        if (bus.in_valid && rdy) mq.push_back(cur_in());
        if (popped || mq.size() > 0) m_zeroed = 1'b0;
      end
    end
  endtask

  task automatic compare();
    exmem_payload_t e;
    check_eq("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
    check_eq("in_ready", 64'(bus.in_ready), 64'(mq.size() < 2));
    if (mq.size() > 0) begin
      e = mq[0];
      check_eq("out_instr", 64'(bus.out_instr), 64'(e.instr));
      check_eq("out_alu", 64'(bus.out_alu), 64'(e.alu));
      check_eq("out_rs2", 64'(bus.out_rs2), 64'(e.rs2));
      check_eq("out_pc", 64'(bus.out_pc), 64'(e.pc));
      check_eq("out_mem_to_reg", 64'(bus.out_mem_to_reg), 64'(e.mem_to_reg));
      check_eq("out_reg_write", 64'(bus.out_reg_write), 64'(e.reg_write));
      check_eq("out_rd", 64'(bus.out_rd), 64'(e.rd));
    end else begin
      check_eq("out_reg_write_empty", 64'(bus.out_reg_write), 64'd0);
      if (m_zeroed) begin
        check_eq("zero_instr", 64'(bus.out_instr), 64'd0);
        check_eq("zero_alu", 64'(bus.out_alu), 64'd0);
        check_eq("zero_rs2", 64'(bus.out_rs2), 64'd0);
        check_eq("zero_pc", 64'(bus.out_pc), 64'd0);
        check_eq("zero_mem_to_reg", 64'(bus.out_mem_to_reg), 64'd0);
        check_eq("zero_rd", 64'(bus.out_rd), 64'd0);
      end
    end
`ifdef EXMEM_STALL_CNT_EN
    check_eq("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  // one clock: model follows the DUT at the edge, outputs checked at negedge
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic push_alu(input logic [31:0] alu);
    exmem_payload_t p;
    p     = rand_payload();
    p.alu = alu;
    set_in(1'b1, p);
  endtask

  initial begin
    exmem_payload_t p;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    set_in(1'b0, '0);
    @(negedge clk);
    step();
    rst = 1'b0;
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);

    // single pass-through entry
    push_alu(32'h1234);
    bus.out_ready = 1'b1;
    step();
    check_eq("pass_out_valid", 64'(bus.out_valid), 64'd1);
    check_eq("pass_out_alu", 64'(bus.out_alu), 64'h1234);
    check_eq("pass_in_ready", 64'(bus.in_ready), 64'd1);
    set_in(1'b0, '0);
    step();

    // fill main and skid while MEM stalls, then drain in order
    bus.out_ready = 1'b0;
    push_alu(32'h1);
    step();
    push_alu(32'h2);
    step();
    check_eq("skid_full_in_ready", 64'(bus.in_ready), 64'd0);
    set_in(1'b0, '0);
    bus.out_ready = 1'b1;
    check_eq("drain_first", 64'(bus.out_alu), 64'h1);
    step();
    check_eq("drain_second", 64'(bus.out_alu), 64'h2);
    check_eq("drain_in_ready", 64'(bus.in_ready), 64'd1);
    step();
    check_eq("drain_empty", 64'(bus.out_valid), 64'd0);

    // flush with skid full and a competing accept
    bus.out_ready = 1'b0;
    push_alu(32'hA);
    step();
    push_alu(32'hB);
    step();
    push_alu(32'hC);
    flush = 1'b1;
    step();
    flush = 1'b0;
    set_in(1'b0, '0);
    check_eq("flush_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("flush_out_alu", 64'(bus.out_alu), 64'd0);
    check_eq("flush_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    step();
    check_eq("flush_no_ghost", 64'(bus.out_valid), 64'd0);

    // flushed forwarding info must vanish
    bus.out_ready = 1'b0;
    p           = rand_payload();
    p.reg_write = 1'b1;
    p.rd        = 5'd7;
    set_in(1'b1, p);
    step();
    set_in(1'b0, '0);
    check_eq("fwd_reg_write", 64'(bus.out_reg_write), 64'd1);
    check_eq("fwd_rd", 64'(bus.out_rd), 64'd7);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("fwd_flush_reg_write", 64'(bus.out_reg_write), 64'd0);
    check_eq("fwd_flush_rd", 64'(bus.out_rd), 64'd0);

`ifdef EXMEM_STALL_CNT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    push_alu(32'h55);
    step();
    set_in(1'b0, '0);
    for (int i = 0; i < 5; i++) step();
    check_eq("stall_five", 64'(stall_cnt), 64'd5);
    bus.out_ready = 1'b1;
    flush         = 1'b1;
    step();
    flush = 1'b0;
    check_eq("stall_after_flush", 64'(stall_cnt), 64'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("stall_after_rst", 64'(stall_cnt), 64'd0);
`endif

    // continuous full-throughput stream
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, rand_payload());
      step();
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 99) < 70, rand_payload());
      bus.out_ready = $urandom_range(0, 99) < 55;
      flush         = $urandom_range(0, 99) < 3;
      rst           = $urandom_range(0, 199) < 1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
